snake_step_sequencer: RTL and testbench

Central controller for the snake game datapath. It turns each free-running game tick into an ordered, handshaked sequence: snake move, field rebuild, collision/apple check, and apple placement when needed. It also owns game start/restart, pause, score, and detection of overruns and stalls. It sits between `tick_timer`/`key_control` and the `snake_calculate` / `field_calculate` / `game_behavior` trio, replacing ad-hoc cross-wiring of their strobes.

---
 rtl/snake_pkg.sv | 23 ++
 rtl/phase_timer.sv | 24 ++
 rtl/snake_step_sequencer.sv | 138 +++++++++++++
 tb/tb_snake_step_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game datapath and its step sequencer.
package snake_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_APPLE,
    S_RUN,
    S_PAUSE,
    S_MOVE,
    S_FIELD,
    S_CHECK,
    S_OVER
  } seq_state_t;

  localparam int DEF_TIMEOUT = 4096;
  localparam int OVR_W       = 8;

  // Playfield geometry used by the field/snake datapaths.
  localparam int FIELD_W     = 32;
  localparam int FIELD_H     = 24;

endpackage

// File: rtl/phase_timer.sv
// Per-phase stall watchdog: reloads on every phase entry, flags expiry TIMEOUT-1 cycles later.
module phase_timer #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Holds at zero once expired so a late done strobe is still seen as expired.
  always_ff @(posedge clk) begin
    if (rst || load) cnt <= LOAD_VAL;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/snake_step_sequencer.sv
// Turns each game tick into a handshaked move/field/check/apple sequence; owns start, pause,
// score, overrun counting and stall detection. All outputs are registered off next state.
module snake_step_sequencer
  import snake_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               pause,
  input  logic               move_done,
  input  logic               field_done,
  input  logic               check_done,
  input  logic               check_dead,
  input  logic               check_grow,
  input  logic               apple_done,
  output logic               game_clr,
  output logic               move_req,
  output logic               field_req,
  output logic               check_req,
  output logic               apple_req,
  output logic               grow,
  output logic               running,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [OVR_W-1:0]   overrun_cnt,
  output logic               timeout_err
);

  seq_state_t state, state_n;
  logic       expired, stall, grow_set, busy;

  // A request register is high only in a phase's first cycle, so it masks same-cycle dones.
  logic move_ok, field_ok, check_ok, apple_ok;
  assign move_ok  = move_done  & ~move_req;
  assign field_ok = field_done & ~field_req;
  assign check_ok = check_done & ~check_req;
  assign apple_ok = apple_done & ~apple_req;

  assign busy = (state == S_MOVE) || (state == S_FIELD) ||
                (state == S_CHECK) || (state == S_APPLE);

  phase_timer #(.TIMEOUT(TIMEOUT)) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state_n != state),
    .expired (expired)
  );

  always_comb begin
    state_n  = state;
    stall    = 1'b0;
    grow_set = 1'b0;
    case (state)
      S_IDLE:  if (start) state_n = S_INIT;
      S_INIT:  state_n = S_APPLE;
      S_RUN: begin
        if (pause)     state_n = S_PAUSE;
        else if (tick) state_n = S_MOVE;
      end
      S_PAUSE: begin
        if (start)      state_n = S_INIT;
        else if (pause) state_n = S_RUN;
      end
      S_MOVE: begin
        if (move_ok)      state_n = S_FIELD;
        else if (expired) begin state_n = S_OVER; stall = 1'b1; end
      end
      S_FIELD: begin
        if (field_ok)     state_n = S_CHECK;
        else if (expired) begin state_n = S_OVER; stall = 1'b1; end
      end
      S_CHECK: begin
        if (check_ok) begin
          if (check_dead)      state_n = S_OVER;
          else if (check_grow) begin state_n = S_APPLE; grow_set = 1'b1; end
          else                 state_n = S_RUN;
        end else if (expired) begin
          state_n = S_OVER;
          stall   = 1'b1;
        end
      end
      S_APPLE: begin
        if (apple_ok)     state_n = S_RUN;
        else if (expired) begin state_n = S_OVER; stall = 1'b1; end
      end
      S_OVER:  if (start) state_n = S_INIT;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      game_clr    <= 1'b0;
      move_req    <= 1'b0;
      field_req   <= 1'b0;
      check_req   <= 1'b0;
      apple_req   <= 1'b0;
      grow        <= 1'b0;
      running     <= 1'b0;
      game_over   <= 1'b0;
      score       <= '0;
      overrun_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_n;
      game_clr  <= (state_n == S_INIT);
      move_req  <= (state_n == S_MOVE)  && (state != S_MOVE);
      field_req <= (state_n == S_FIELD) && (state != S_FIELD);
      check_req <= (state_n == S_CHECK) && (state != S_CHECK);
      apple_req <= (state_n == S_APPLE) && (state != S_APPLE);
      running   <= (state_n == S_APPLE) || (state_n == S_RUN) || (state_n == S_MOVE) ||
                   (state_n == S_FIELD) || (state_n == S_CHECK);
      game_over <= (state_n == S_OVER);
      if (state_n == S_INIT) begin
        score       <= '0;
        overrun_cnt <= '0;
        timeout_err <= 1'b0;
        grow        <= 1'b0;
      end else begin
        if (grow_set) begin
          grow <= 1'b1;
          if (score != '1) score <= score + 1'b1;
        end else if (state == S_APPLE && apple_ok) begin
          grow <= 1'b0;
        end
        // Ticks landing mid-step are dropped, only counted.
        if (tick && busy && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
        if (stall) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Bench for snake_step_sequencer: directed vector table, corner sequences, random run vs. a cycle model.
module tb_snake_step_sequencer;

  localparam int MT = 64;

  logic clk = 1'b0;
  logic rst, tick, start, pause, move_done, field_done, check_done, check_dead, check_grow, apple_done;

  logic        game_clr, move_req, field_req, check_req, apple_req, grow, running, game_over, timeout_err;
  logic [15:0] score;
  logic [7:0]  overrun_cnt;
  logic        s_game_clr, s_move_req, s_field_req, s_check_req, s_apple_req, s_grow, s_running;
  logic        s_game_over, s_timeout_err;
  logic [15:0] s_score;
  logic [7:0]  s_overrun_cnt;

  always #5 clk = ~clk;

  snake_step_sequencer #(.TIMEOUT(MT), .SCORE_W(16)) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
    .move_done(move_done), .field_done(field_done), .check_done(check_done),
    .check_dead(check_dead), .check_grow(check_grow), .apple_done(apple_done),
    .game_clr(game_clr), .move_req(move_req), .field_req(field_req), .check_req(check_req),
    .apple_req(apple_req), .grow(grow), .running(running), .game_over(game_over),
    .score(score), .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  snake_step_sequencer #(.TIMEOUT(16), .SCORE_W(16)) u_stl (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
    .move_done(move_done), .field_done(field_done), .check_done(check_done),
    .check_dead(check_dead), .check_grow(check_grow), .apple_done(apple_done),
    .game_clr(s_game_clr), .move_req(s_move_req), .field_req(s_field_req), .check_req(s_check_req),
    .apple_req(s_apple_req), .grow(s_grow), .running(s_running), .game_over(s_game_over),
    .score(s_score), .overrun_cnt(s_overrun_cnt), .timeout_err(s_timeout_err)
  );

  logic [7:0] outs;
  assign outs = {game_clr, move_req, field_req, check_req, apple_req, grow, running, game_over};

  // input bit order: {tick,start,pause,move_done,field_done,check_done,check_dead,check_grow,apple_done}
  localparam logic [8:0] I_NONE = 9'b000000000, I_TICK = 9'b100000000, I_START = 9'b010000000,
                         I_PAUSE = 9'b001000000, I_MD = 9'b000100000, I_FD = 9'b000010000,
                         I_CD = 9'b000001000, I_DEAD = 9'b000000100, I_GRW = 9'b000000010,
                         I_AD = 9'b000000001;

  typedef struct packed {
    logic [8:0]  in;
    logic [7:0]  exp;   // {clr,mreq,freq,creq,areq,grow,running,game_over}
    logic [15:0] sc;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: phase mode plus cycles spent in it.
  localparam int M_IDLE = 0, M_INIT = 1, M_APPLE = 2, M_RUN = 3, M_PAUSE = 4,
                 M_MOVE = 5, M_FIELD = 6, M_CHECK = 7, M_OVER = 8;
  int m_mode = M_IDLE, m_age = 0, m_score = 0, m_ovr = 0;
  bit m_terr = 0, m_grow = 0;

  task automatic set_in(input logic [8:0] v);
    {tick, start, pause, move_done, field_done, check_done, check_dead, check_grow, apple_done} = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int nm;
    bit phase, done;
    if (rst) begin
      m_mode = M_IDLE; m_age = 0; m_score = 0; m_ovr = 0; m_terr = 0; m_grow = 0;
      return;
    end
    nm    = m_mode;
    phase = (m_mode == M_MOVE || m_mode == M_FIELD || m_mode == M_CHECK || m_mode == M_APPLE);
    done  = (m_age > 0) && ((m_mode == M_MOVE && move_done) || (m_mode == M_FIELD && field_done) ||
                            (m_mode == M_CHECK && check_done) || (m_mode == M_APPLE && apple_done));
    if (phase && tick && m_ovr < 255) m_ovr++;
    case (m_mode)
      M_IDLE:  if (start) nm = M_INIT;
      M_INIT:  nm = M_APPLE;
      M_RUN:   if (pause) nm = M_PAUSE; else if (tick) nm = M_MOVE;
      M_PAUSE: if (start) nm = M_INIT; else if (pause) nm = M_RUN;
      M_OVER:  if (start) nm = M_INIT;
      default: begin
        if (done) begin
          case (m_mode)
            M_MOVE:  nm = M_FIELD;
            M_FIELD: nm = M_CHECK;
            M_APPLE: begin nm = M_RUN; m_grow = 0; end
            default: begin
              if (check_dead) nm = M_OVER;
              else if (check_grow) begin
                nm = M_APPLE; m_grow = 1;
                if (m_score < 65535) m_score++;
              end else nm = M_RUN;
            end
          endcase
        end else if (m_age == MT - 1) begin
          nm = M_OVER; m_terr = 1;
        end
      end
    endcase
    if (nm == M_INIT) begin m_score = 0; m_ovr = 0; m_terr = 0; m_grow = 0; end
    m_age  = (nm == m_mode) ? m_age + 1 : 0;
    m_mode = nm;
  endtask

  function automatic logic [7:0] m_outs();
    logic act;
    act = (m_mode == M_APPLE || m_mode == M_RUN || m_mode == M_MOVE ||
           m_mode == M_FIELD || m_mode == M_CHECK);
    return {m_mode == M_INIT, m_mode == M_MOVE && m_age == 0, m_mode == M_FIELD && m_age == 0,
            m_mode == M_CHECK && m_age == 0, m_mode == M_APPLE && m_age == 0, m_grow, act,
            m_mode == M_OVER};
  endfunction

  // One clock: DUT and model both sample the held inputs, then outputs are compared.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("model_outs", 32'(outs), 32'(m_outs()));
    chk("model_score", 32'(score), m_score);
    chk("model_overrun", 32'(overrun_cnt), m_ovr);
    chk("model_timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  vec_t tbl [35];

  initial begin
    tbl = '{
      '{I_START,        8'b1000_0000, 16'd0},  // INIT
      '{I_NONE,         8'b0000_1010, 16'd0},  // first apple request
      '{I_NONE,         8'b0000_0010, 16'd0},
      '{I_NONE,         8'b0000_0010, 16'd0},
      '{I_NONE,         8'b0000_0010, 16'd0},
      '{I_AD,           8'b0000_0010, 16'd0},  // apple_done 3 cycles after request
      '{I_TICK,         8'b0100_0010, 16'd0},  // N+1 move_req
      '{I_NONE,         8'b0000_0010, 16'd0},
      '{I_MD,           8'b0010_0010, 16'd0},  // N+3 field_req
      '{I_NONE,         8'b0000_0010, 16'd0},
      '{I_FD,           8'b0001_0010, 16'd0},  // N+5 check_req
      '{I_NONE,         8'b0000_0010, 16'd0},
      '{I_CD,           8'b0000_0010, 16'd0},  // N+7 back in RUN
      '{I_TICK,         8'b0100_0010, 16'd0},
      '{I_MD,           8'b0000_0010, 16'd0},  // done with request: ignored
      '{I_MD,           8'b0010_0010, 16'd0},
      '{I_NONE,         8'b0000_0010, 16'd0},
      '{I_FD,           8'b0001_0010, 16'd0},
      '{I_NONE,         8'b0000_0010, 16'd0},
      '{I_CD | I_GRW,   8'b0000_1110, 16'd1},  // grow: score+1, apple request
      '{I_AD,           8'b0000_0110, 16'd1},  // ignored, same cycle as apple_req
      '{I_AD,           8'b0000_0010, 16'd1},  // grow drops
      '{I_TICK|I_PAUSE, 8'b0000_0000, 16'd1},  // pause wins
      '{I_TICK,         8'b0000_0000, 16'd1},
      '{I_PAUSE,        8'b0000_0010, 16'd1},
      '{I_TICK,         8'b0100_0010, 16'd1},
      '{I_NONE,         8'b0000_0010, 16'd1},
      '{I_MD,           8'b0010_0010, 16'd1},
      '{I_FD | I_START, 8'b0000_0010, 16'd1},  // both ignored
      '{I_FD,           8'b0001_0010, 16'd1},
      '{I_NONE,         8'b0000_0010, 16'd1},
      '{I_CD|I_DEAD|I_GRW, 8'b0000_0001, 16'd1},  // dead beats grow
      '{I_TICK|I_PAUSE|I_MD, 8'b0000_0001, 16'd1},
      '{I_START,        8'b1000_0000, 16'd0},
      '{I_NONE,         8'b0000_1010, 16'd0}
    };

    rst = 1'b1;
    set_in(I_NONE);
    step();
    chk("reset_outs", 32'({outs, score, overrun_cnt, timeout_err}), 32'd0);
    chk("reset_stl_outs", 32'({s_game_clr, s_move_req, s_apple_req, s_running, s_game_over,
                               s_timeout_err, s_score}), 32'd0);
    step();
    rst = 1'b0;

    foreach (tbl[i]) begin
      set_in(tbl[i].in);
      step();
      chk($sformatf("tbl%0d_outs", i), 32'(outs), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d_score", i), 32'(score), 32'(tbl[i].sc));
    end

    // Three ticks during a 20-cycle FIELD phase.
    set_in(I_NONE); step();
    set_in(I_AD);   step();
    set_in(I_TICK); step();
    set_in(I_NONE); step();
    set_in(I_MD);   step();
    for (int k = 1; k <= 20; k++) begin
      set_in((k == 3 || k == 9 || k == 15) ? I_TICK : I_NONE);
      step();
    end
    set_in(I_FD);   step();
    set_in(I_NONE); step();
    set_in(I_CD);   step();
    chk("overrun_3", 32'(overrun_cnt), 32'd3);

    // 300 ticks with periodic dones: counter must pin at 255.
    for (int k = 0; k < 300; k++) begin
      set_in(I_TICK | (((k % 3) == 2) ? (I_MD | I_FD | I_CD | I_AD) : I_NONE));
      step();
    end
    set_in(I_NONE); step();
    chk("overrun_sat", 32'(overrun_cnt), 32'd255);

    // Stall on the TIMEOUT=16 instance: field_done withheld.
    rst = 1'b1; step(); rst = 1'b0;
    set_in(I_START); step();
    set_in(I_NONE);  step();
    set_in(I_NONE);  step();
    set_in(I_AD);    step();
    set_in(I_TICK);  step();
    set_in(I_NONE);  step();
    set_in(I_MD);    step();
    chk("stl_field_req", 32'(s_field_req), 32'd1);
    set_in(I_NONE);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) chk("stl_pre", 32'({s_timeout_err, s_game_over}), 32'd0);
      if (k == 16) chk("stl_hit", 32'({s_timeout_err, s_game_over}), 32'b11);
    end
    set_in(I_START); step();
    chk("stl_restart", 32'({s_game_clr, s_timeout_err, s_game_over}), 32'b100);

    // Reset while the main instance sits in CHECK.
    set_in(I_FD); step();
    chk("check_entry", 32'(check_req), 32'd1);
    set_in(I_NONE);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_in_check", 32'({outs, score, overrun_cnt, timeout_err}), 32'd0);

    for (int k = 0; k < 2500; k++) begin
      rst        = ($urandom_range(0, 499) == 0);
      tick       = ($urandom_range(0, 3) == 0);
      start      = ($urandom_range(0, 31) == 0);
      pause      = ($urandom_range(0, 31) == 0);
      move_done  = ($urandom_range(0, 2) == 0);
      field_done = ($urandom_range(0, 2) == 0);
      check_done = ($urandom_range(0, 2) == 0);
      check_dead = ($urandom_range(0, 7) == 0);
      check_grow = ($urandom_range(0, 2) == 0);
      apple_done = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
